carry_save_8: RTL and testbench

CARRY_SAVE_8 -- requirements
Module: carry_save_8

---
 rtl/carry_save_8_pkg.sv | 46 ++++
 rtl/carry_save_8_csa_3to2.sv | 20 ++
 rtl/carry_save_8.sv | 141 ++++++++++++++
 tb/tb_carry_save_8.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/carry_save_8_pkg.sv
// carry_save_8_pkg: shared types, widths and helpers for the carry-save multiplier back end.
// Holds the element-width encoding, FSM states and partial-product weighting helpers.
package carry_save_8_pkg;

    localparam int PP_W    = 16;
    localparam int ACC_W   = 64;
    localparam int BYTE_SH = 8;

    typedef enum logic [1:0] {
        SEW_8   = 2'b00,
        SEW_16  = 2'b01,
        SEW_32  = 2'b10,
        SEW_RSV = 2'b11
    } sew_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CYCLE1 = 2'b01,
        CYCLE2 = 2'b10,
        DONE   = 2'b11
    } state_e;

    // pp index p = 4*row + col carries weight 2^(8*(row+col))
    function automatic logic [ACC_W-1:0] pp_weight(
        input logic [PP_W-1:0] v,
        input logic [3:0]      p
    );
        logic [2:0] pos;
        pos = {1'b0, p[3:2]} + {1'b0, p[1:0]};
        return {{(ACC_W-PP_W){1'b0}}, v} << {pos, 3'b000};
    endfunction

    // One 16x16 element from four 8x8 partial products, kept modulo 2^32
    function automatic logic [31:0] sew16_sum(
        input logic [PP_W-1:0] a,
        input logic [PP_W-1:0] b,
        input logic [PP_W-1:0] c,
        input logic [PP_W-1:0] d
    );
        return {16'b0, a}
             + {8'b0, b, 8'b0}
             + {8'b0, c, 8'b0}
             + {d, 16'b0};
    endfunction

endpackage

// File: rtl/carry_save_8_csa_3to2.sv
// csa_3to2: parameterized 3:2 carry-save compressor.
// Ports: a, b, c (W-bit addends) -> sum, carry (carry pre-shifted left by one, modulo 2^W).
module csa_3to2 #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum = a ^ b ^ c;

    // Top majority bit would shift out of range, so it is never formed
    assign carry = {(a[W-2:0] & b[W-2:0])
                  | (a[W-2:0] & c[W-2:0])
                  | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/carry_save_8.sv
// carry_save_8: combines eight 8x8 partial products into 8/16/32-bit element products.
// Ports: clk, reset (async high), start, sew[1:0], mult_out_1..8[15:0] -> product_1..4[31:0].
module carry_save_8
    import carry_save_8_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  sew,
    input  logic [15:0] mult_out_1,
    input  logic [15:0] mult_out_2,
    input  logic [15:0] mult_out_3,
    input  logic [15:0] mult_out_4,
    input  logic [15:0] mult_out_5,
    input  logic [15:0] mult_out_6,
    input  logic [15:0] mult_out_7,
    input  logic [15:0] mult_out_8,
    output logic [31:0] product_1,
    output logic [31:0] product_2,
    output logic [31:0] product_3,
    output logic [31:0] product_4
);

    state_e           state_q, state_d;
    sew_e             sew_q, sew_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [31:0]      prod_q [4];
    logic [31:0]      prod_d [4];

    logic [PP_W-1:0]  mo [8];
    logic [ACC_W-1:0] t  [9];
    logic [ACC_W-1:0] s1 [3];
    logic [ACC_W-1:0] c1 [3];
    logic [ACC_W-1:0] s2 [2];
    logic [ACC_W-1:0] c2 [2];
    logic [ACC_W-1:0] s3, c3, s4, c4;
    logic [ACC_W-1:0] tree_sum;
    logic [3:0]       pp_base;

    assign mo[0] = mult_out_1;
    assign mo[1] = mult_out_2;
    assign mo[2] = mult_out_3;
    assign mo[3] = mult_out_4;
    assign mo[4] = mult_out_5;
    assign mo[5] = mult_out_6;
    assign mo[6] = mult_out_7;
    assign mo[7] = mult_out_8;

    // First cycle carries pp 0..7 (B rows 0,1), second cycle pp 8..15
    assign pp_base = (state_q == CYCLE2) ? 4'd8 : 4'd0;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            t[k] = pp_weight(mo[k], 4'(k) + pp_base);
        end
        t[8] = acc_q;
    end

    csa_3to2 #(.W(ACC_W)) u_l1_0 (.a(t[0]), .b(t[1]), .c(t[2]), .sum(s1[0]), .carry(c1[0]));
    csa_3to2 #(.W(ACC_W)) u_l1_1 (.a(t[3]), .b(t[4]), .c(t[5]), .sum(s1[1]), .carry(c1[1]));
    csa_3to2 #(.W(ACC_W)) u_l1_2 (.a(t[6]), .b(t[7]), .c(t[8]), .sum(s1[2]), .carry(c1[2]));
    csa_3to2 #(.W(ACC_W)) u_l2_0 (.a(s1[0]), .b(c1[0]), .c(s1[1]), .sum(s2[0]), .carry(c2[0]));
    csa_3to2 #(.W(ACC_W)) u_l2_1 (.a(c1[1]), .b(s1[2]), .c(c1[2]), .sum(s2[1]), .carry(c2[1]));
    csa_3to2 #(.W(ACC_W)) u_l3   (.a(s2[0]), .b(c2[0]), .c(s2[1]), .sum(s3), .carry(c3));
    csa_3to2 #(.W(ACC_W)) u_l4   (.a(s3), .b(c3), .c(c2[1]), .sum(s4), .carry(c4));

    assign tree_sum = s4 + c4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sew_q   <= SEW_8;
            acc_q   <= '0;
            for (int i = 0; i < 4; i++) prod_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sew_q   <= sew_d;
            acc_q   <= acc_d;
            for (int i = 0; i < 4; i++) prod_q[i] <= prod_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CYCLE1;
            CYCLE1:  state_d = (sew_q == SEW_32) ? CYCLE2 : DONE;
            CYCLE2:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sew_d = sew_q;
        acc_d = acc_q;
        for (int i = 0; i < 4; i++) prod_d[i] = prod_q[i];
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sew_d = sew_e'(sew);
                    acc_d = '0;
                end
            end
            CYCLE1: begin
                unique case (sew_q)
                    SEW_32: acc_d = tree_sum;
                    SEW_16: begin
                        prod_d[0] = sew16_sum(mo[0], mo[1], mo[2], mo[3]);
                        prod_d[1] = sew16_sum(mo[4], mo[5], mo[6], mo[7]);
                        prod_d[2] = '0;
                        prod_d[3] = '0;
                    end
                    SEW_8: begin
                        prod_d[0] = {mo[1], mo[0]};
                        prod_d[1] = {mo[3], mo[2]};
                        prod_d[2] = {mo[5], mo[4]};
                        prod_d[3] = {mo[7], mo[6]};
                    end
                    default: begin
                        for (int i = 0; i < 4; i++) prod_d[i] = '0;
                    end
                endcase
            end
            CYCLE2: begin
                acc_d     = tree_sum;
                prod_d[0] = tree_sum[31:0];
                prod_d[1] = tree_sum[63:32];
                prod_d[2] = '0;
                prod_d[3] = '0;
            end
            default: ;
        endcase
    end

    assign product_1 = prod_q[0];
    assign product_2 = prod_q[1];
    assign product_3 = prod_q[2];
    assign product_4 = prod_q[3];

endmodule

// File: tb/tb_carry_save_8.sv
// tb_carry_save_8: directed self-checking bench for carry_save_8.
// Drives hand-computed vectors and checks products with immediate assertions.
module tb_carry_save_8;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  sew;
    logic [15:0] m1, m2, m3, m4, m5, m6, m7, m8;
    logic [31:0] product_1, product_2, product_3, product_4;

    int total = 0;
    int bad   = 0;

    carry_save_8 dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sew        (sew),
        .mult_out_1 (m1),
        .mult_out_2 (m2),
        .mult_out_3 (m3),
        .mult_out_4 (m4),
        .mult_out_5 (m5),
        .mult_out_6 (m6),
        .mult_out_7 (m7),
        .mult_out_8 (m8),
        .product_1  (product_1),
        .product_2  (product_2),
        .product_3  (product_3),
        .product_4  (product_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [15:0] v);
        m1 = v; m2 = v; m3 = v; m4 = v;
        m5 = v; m6 = v; m7 = v; m8 = v;
    endtask

    task automatic chk(input string tag, input logic [127:0] exp);
        logic [127:0] obs;
        obs = {product_4, product_3, product_2, product_1};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sew   = 2'b00;
        set_all(16'h0);
        tick();
        tick();
        chk("reset_state", 128'h0);
        reset = 1'b0;
        tick();

        // 32-bit all-ones, sew input changed after latch
        start = 1'b1; sew = 2'b10; tick();
        start = 1'b0; sew = 2'b00; set_all(16'hFE01); tick();
        chk("s32_mid_hold", 128'h0);
        tick();
        chk("s32_ones", {64'h0, 64'hFFFFFFFE_00000001});
        tick();

        // 32-bit single partial product pp3
        start = 1'b1; sew = 2'b10; set_all(16'h0); tick();
        start = 1'b0; m4 = 16'h0100; tick();
        set_all(16'h0); tick();
        chk("s32_pp3", {64'h0, 64'h00000001_00000000});
        tick();

        // 16-bit elements
        start = 1'b1; sew = 2'b01; tick();
        start = 1'b0; set_all(16'h0);
        m1 = 16'hFE01; m2 = 16'hFE01; m3 = 16'hFE01; m4 = 16'hFE01;
        m5 = 16'h0006;
        tick();
        chk("s16_basic", {32'h0, 32'h0, 32'h00000006, 32'hFFFE0001});
        tick();

        // 16-bit modulo 2^32 wrap
        start = 1'b1; sew = 2'b01; tick();
        start = 1'b0; set_all(16'hFFFF); tick();
        chk("s16_wrap", {32'h0, 32'h0, 32'h01FFFDFF, 32'h01FFFDFF});
        tick();

        // 8-bit elements
        start = 1'b1; sew = 2'b00; tick();
        start = 1'b0; set_all(16'h0);
        m1 = 16'h0001; m2 = 16'hFE01; m7 = 16'h00FF;
        tick();
        chk("s8_basic", {32'h000000FF, 32'h0, 32'h0, 32'hFE010001});
        tick();
        chk("s8_hold_idle", {32'h000000FF, 32'h0, 32'h0, 32'hFE010001});

        // reserved width clears products with 8-bit timing
        start = 1'b1; sew = 2'b11; tick();
        start = 1'b0; set_all(16'h1234); tick();
        chk("s11_zero", 128'h0);
        tick();

        // load nonzero then reset during CYCLE2
        start = 1'b1; sew = 2'b00; tick();
        start = 1'b0; set_all(16'hA5A5); tick();
        chk("s8_fill", {4{32'hA5A5A5A5}});
        tick();
        start = 1'b1; sew = 2'b10; tick();
        start = 1'b0; set_all(16'hFE01); tick();
        reset = 1'b1;
        #1;
        chk("reset_async", 128'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("reset_discard", 128'h0);
        start = 1'b1; sew = 2'b10; set_all(16'h0); tick();
        start = 1'b0; set_all(16'hFE01); tick();
        tick();
        chk("post_reset_s32", {64'h0, 64'hFFFFFFFE_00000001});
        tick();

        // back-to-back with start held high
        start = 1'b1; sew = 2'b10; set_all(16'h0); tick();
        set_all(16'hFE01); tick();
        tick();
        chk("b2b_first", {64'h0, 64'hFFFFFFFE_00000001});
        set_all(16'hFFFF); tick();
        chk("b2b_hold_e3", {64'h0, 64'hFFFFFFFE_00000001});
        tick();
        chk("b2b_hold_e4", {64'h0, 64'hFFFFFFFE_00000001});
        set_all(16'h0); m4 = 16'h0100; tick();
        chk("b2b_hold_e5", {64'h0, 64'hFFFFFFFE_00000001});
        set_all(16'h0); tick();
        chk("b2b_second", {64'h0, 64'h00000001_00000000});
        start = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
